// File: rtl/serv_wb_nibble_bridge.sv
// Wishbone-classic slave that serialises each bus cycle into a 4-bit command stream
// and reassembles 4-bit read-response nibbles into 32-bit read data.
module serv_wb_nibble_bridge #(
   parameter int ADDR_NIBBLES = 8,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic [3:0]  o_cmd_dat,
   output logic        o_cmd_valid,
   input  logic        i_cmd_ready,
   input  logic [3:0]  i_rsp_dat,
   input  logic        i_rsp_valid,
   output logic        o_err
);

   localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, HDR, ADDR, SEL, WDATA, RESP, ACK} state_t;

   state_t           state;
   logic             guard;
   logic [2:0]       cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [31:0]      adr_r;
   logic [31:0]      dat_r;
   logic [3:0]       sel_r;
   logic             we_r;
   logic [31:0]      asm_r;
   logic             start;
   logic             rsp_last;
   logic             tmo_hit;

   function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] idx);
      return w[{idx, 2'b00} +: 4];
   endfunction

   // guard blocks a new launch in the cycle right after ack, while the master still holds cyc
   assign start    = (state == IDLE) && !guard && i_wb_cyc;
   assign rsp_last = i_rsp_valid && (cnt == 3'd7);
   assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (start) begin
         adr_r <= i_wb_adr;
         dat_r <= i_wb_dat;
         sel_r <= i_wb_sel;
         we_r  <= i_wb_we;
      end
   end

   always_ff @(posedge clk) begin
      if (state == RESP && i_rsp_valid)
         asm_r <= {asm_r[27:0], i_rsp_dat};
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state       <= IDLE;
         guard       <= 1'b0;
         cnt         <= 3'd0;
         tmo_cnt     <= '0;
         o_cmd_valid <= 1'b0;
         o_cmd_dat   <= 4'h0;
         o_wb_ack    <= 1'b0;
         o_err       <= 1'b0;
         o_wb_rdt    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               guard <= 1'b0;
               if (start) begin
                  state       <= HDR;
                  o_cmd_valid <= 1'b1;
                  o_cmd_dat   <= {1'b1, i_wb_we, 2'b00};
               end
            end
            HDR: if (i_cmd_ready) begin
               state     <= ADDR;
               cnt       <= 3'(ADDR_NIBBLES - 1);
               o_cmd_dat <= nib(adr_r, 3'(ADDR_NIBBLES - 1));
            end
            ADDR: if (i_cmd_ready) begin
               if (cnt == 3'd0) begin
                  if (we_r) begin
                     state     <= SEL;
                     o_cmd_dat <= sel_r;
                  end else begin
                     state       <= RESP;
                     o_cmd_valid <= 1'b0;
                     o_cmd_dat   <= 4'h0;
                     tmo_cnt     <= '0;
                  end
               end else begin
                  cnt       <= cnt - 3'd1;
                  o_cmd_dat <= nib(adr_r, cnt - 3'd1);
               end
            end
            SEL: if (i_cmd_ready) begin
               state     <= WDATA;
               cnt       <= 3'd7;
               o_cmd_dat <= dat_r[31:28];
            end
            WDATA: if (i_cmd_ready) begin
               if (cnt == 3'd0) begin
                  state       <= ACK;
                  o_cmd_valid <= 1'b0;
                  o_cmd_dat   <= 4'h0;
                  o_wb_ack    <= 1'b1;
               end else begin
                  cnt       <= cnt - 3'd1;
                  o_cmd_dat <= nib(dat_r, cnt - 3'd1);
               end
            end
            RESP: begin
               // a final nibble in the same cycle as the timeout wins
               if (rsp_last) begin
                  state    <= ACK;
                  o_wb_ack <= 1'b1;
                  o_wb_rdt <= {asm_r[27:0], i_rsp_dat};
                  cnt      <= 3'd0;
               end else begin
                  if (i_rsp_valid)
                     cnt <= cnt + 3'd1;
                  if (tmo_hit) begin
                     state    <= ACK;
                     o_wb_ack <= 1'b1;
                     o_err    <= 1'b1;
                     o_wb_rdt <= 32'hFFFF_FFFF;
                     cnt      <= 3'd0;
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
               end
            end
            ACK: begin
               o_wb_ack <= 1'b0;
               o_err    <= 1'b0;
               guard    <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
